// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg: shared state encoding, default word width and saturating counter helper for the SPI responder.
package myo_spi_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int WORD_W_DEF = 16;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/myo_spi_sync.sv
// myo_spi_sync: two-flop synchroniser plus a third flop for rise/fall pulse detection.
module myo_spi_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s <= '0;
    else s <= {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/myo_spi_responder.sv
// myo_spi_responder: oversampled mode-0 SPI slave with a local transmit buffer and per-word/per-frame reporting.
// Optional frame XOR checksum enabled by MYO_SPI_RESPONDER_CHECKSUM_EN.
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic              tx_wr_en,
  input  logic [AW-1:0]     tx_wr_addr,
  input  logic [WORD_W-1:0] tx_wr_data,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_data,
  output logic [7:0]        rx_index,
  output logic              frame_done,
  output logic [7:0]        frame_words,
  output logic              frame_error,
  output logic              busy
);
  localparam int BW = $clog2(WORD_W + 1);
  state_t state, state_nx;
  logic sck_s, sck_rise, sck_fall, mosi_s, mosi_rise, mosi_fall, ss_s, ss_rise, ss_fall;
  logic unused_sync;
  logic [WORD_W-1:0] tx_buf [DEPTH];
  logic [WORD_W-1:0] tx_shift, rx_shift;
  logic [BW-1:0] bitcnt;
  logic [7:0] wordcnt;
  logic word_done, csum_err;

  myo_spi_sync u_sck (.clk(clk), .reset_n(reset_n), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
  myo_spi_sync u_mosi (.clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  myo_spi_sync u_ss (.clk(clk), .reset_n(reset_n), .d(ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall));
  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall, ss_s};

  assign busy = state == ACTIVE;
  assign miso_oe = busy;
  assign miso = busy & tx_shift[WORD_W-1];
  // The full word sits in rx_shift one cycle after its last sck rise.
  assign word_done = busy && bitcnt == BW'(WORD_W);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < DEPTH; i++) tx_buf[i] <= '0;
    else if (tx_wr_en) tx_buf[tx_wr_addr] <= tx_wr_data;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && ss_fall) ? ACTIVE : (state == ACTIVE && ss_rise) ? IDLE : state;
  end

`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) csum <= '0;
    else if (state == IDLE && ss_fall) csum <= '0;
    else if (word_done && !ss_rise) csum <= csum ^ rx_shift;
  assign csum_err = wordcnt >= 8'd2 && csum != '0;
`else
  assign csum_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bitcnt <= '0;
      wordcnt <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_index <= '0;
      frame_done <= 1'b0;
      frame_words <= '0;
      frame_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (ss_fall) begin
          bitcnt <= '0;
          wordcnt <= '0;
          tx_shift <= tx_buf[0];
        end
      end else if (ss_rise) begin
        frame_done <= 1'b1;
        frame_words <= wordcnt;
        frame_error <= bitcnt != '0 || csum_err;
      end else if (word_done) begin
        rx_data <= rx_shift;
        rx_index <= wordcnt;
        rx_valid <= 1'b1;
        wordcnt <= sat_inc8(wordcnt);
        bitcnt <= '0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
        bitcnt <= bitcnt + BW'(1);
      end else if (sck_fall) begin
        tx_shift <= (bitcnt == '0 && wordcnt != '0)
                  ? ((32'(wordcnt) >= DEPTH) ? '0 : tx_buf[wordcnt[AW-1:0]])
                  : tx_shift << 1;
      end
    end
endmodule

// File: tb/tb_myo_spi_responder.sv
// tb_myo_spi_responder: SPI master model driving frames with a scoreboard of expected words and frame reports.
module tb_myo_spi_responder;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clk = 0, reset_n = 0, sck = 0, mosi = 0, ss_n = 1;
  logic tx_wr_en = 0;
  logic [2:0] tx_wr_addr = 0;
  logic [15:0] tx_wr_data = 0;
  logic miso, miso_oe, rx_valid, frame_done, frame_error, busy;
  logic [15:0] rx_data;
  logic [7:0] rx_index, frame_words;
  int tests = 0, fails = 0;
  int idx;
  logic [15:0] xr;
  typedef struct {logic [15:0] d; logic [7:0] i;} rx_t;
  typedef struct {logic [7:0] n; logic e;} fr_t;
  rx_t rx_q[$];
  fr_t fr_q[$];

  myo_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr),
    .tx_wr_data(tx_wr_data), .rx_valid(rx_valid), .rx_data(rx_data), .rx_index(rx_index),
    .frame_done(frame_done), .frame_words(frame_words), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (reset_n && rx_valid) begin
    rx_t e;
    if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_valid), 0);
    else begin
      e = rx_q.pop_front();
      check("rx_data", 32'(rx_data), 32'(e.d));
      check("rx_index", 32'(rx_index), 32'(e.i));
    end
  end

  always @(negedge clk) if (reset_n && frame_done) begin
    fr_t e;
    if (fr_q.size() == 0) check("frame_unexpected", 32'(frame_done), 0);
    else begin
      e = fr_q.pop_front();
      check("frame_words", 32'(frame_words), 32'(e.n));
      check("frame_error", 32'(frame_error), 32'(e.e));
    end
  end

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    tx_wr_en = 1; tx_wr_addr = 3'(a); tx_wr_data = d;
    @(negedge clk);
    tx_wr_en = 0;
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ss_n = 0; idx = 0; xr = 0;
    repeat (4) @(negedge clk);
    check("busy_active", 32'(busy), 1);
    check("miso_oe_active", 32'(miso_oe), 1);
  endtask

  task automatic send_word(input logic [15:0] w, input int nb, input bit chk, input logic [15:0] exp_miso);
    logic [15:0] got = 0;
    for (int b = 15; b > 15 - nb; b--) begin
      mosi = w[b];
      repeat (4) @(negedge clk);
      got[b] = miso;
      sck = 1;
      repeat (4) @(negedge clk);
      sck = 0;
    end
    if (nb == 16) begin
      rx_q.push_back('{w, 8'(idx)});
      xr ^= w;
      idx = idx < 255 ? idx + 1 : 255;
      if (chk) check("miso_word", 32'(got), 32'(exp_miso));
    end
  endtask

  task automatic frame_end(input bit partial);
    repeat (4) @(negedge clk);
    ss_n = 1;
    fr_q.push_back('{8'(idx), partial | (CS && idx >= 2 && xr != 0)});
    repeat (12) @(negedge clk);
    check("busy_idle", 32'(busy), 0);
    check("miso_idle", 32'({miso_oe, miso}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a", 32'({miso, miso_oe, rx_valid, frame_done, frame_error, busy, rx_data}), 0);
    check("rst_b", 32'({rx_index, frame_words}), 0);
    reset_n = 1;
    repeat (10) @(negedge clk);
    check("idle_after_rst", 32'(busy), 0);

    wr(0, 16'hA5A5); wr(1, 16'h1234); wr(2, 16'hFFFF);
    frame_begin();
    send_word(16'h8001, 16, 1, 16'hA5A5);
    send_word(16'h0002, 16, 1, 16'h1234);
    send_word(16'h0003, 16, 1, 16'hFFFF);
    frame_end(0);

    frame_begin();
    send_word(16'h8001, 16, 1, 16'hA5A5);
    send_word(16'hA000, 4, 0, 16'h0000);
    frame_end(1);

    for (int i = 0; i < 8; i++) wr(i, 16'hC000 | 16'(i));
    frame_begin();
    for (int i = 0; i < 10; i++) send_word(16'h0107 * 16'(i + 1), 16, 1, i < 8 ? 16'hC000 | 16'(i) : 16'h0000);
    frame_end(0);

    frame_begin();
    send_word(16'hFFFF, 5, 0, 16'h0000);
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (10) @(negedge clk);
    check("busy_after_midframe_rst", 32'(busy), 0);
    ss_n = 1;
    repeat (12) @(negedge clk);
    frame_begin();
    send_word(16'hBEEF, 16, 1, 16'h0000);
    frame_end(0);

    frame_begin();
    send_word(16'h1111, 16, 1, 16'h0000);
    send_word(16'h2222, 16, 1, 16'h0000);
    send_word(16'h3333, 16, 1, 16'h0000);
    frame_end(0);
    frame_begin();
    send_word(16'h1111, 16, 1, 16'h0000);
    send_word(16'h2222, 16, 1, 16'h0000);
    send_word(16'h3334, 16, 1, 16'h0000);
    frame_end(0);

    wr(0, 16'h0F0F); wr(1, 16'h0000);
    fork
      begin
        frame_begin();
        send_word(16'h4321, 16, 1, 16'h0F0F);
        send_word(16'h8765, 16, 1, 16'h5A5A);
        frame_end(0);
      end
      begin
        repeat (40) @(negedge clk);
        wr(1, 16'h5A5A);
      end
    join

    repeat (20) @(negedge clk);
    check("rx_q_drained", rx_q.size(), 0);
    check("fr_q_drained", fr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
